// File: rtl/fifo_serial_pkg.sv
// Shared types and line levels for the FIFO-fed serial transmitter.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period counter: bit_tick pulses in the last clk cycle of every
// CLKS_PER_BIT-cycle bit period; clr holds the count at zero.
module serial_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = (cnt_q == LAST);
    cnt_d    = (clr || bit_tick) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a FIFO via pop/pndng and sends each word as start, LSB-first data,
// optional even parity (FIFO_SERIAL_TX_PARITY_EN) and stop bit.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int unsigned BITS         = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] Din,
  input  logic            pndng,
  output logic            pop,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int unsigned BCW = (BITS > 1) ? $clog2(BITS) : 1;

  tx_state_t       state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_tick;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  serial_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pndng && rst) begin
          pop     = 1'b1;
          shift_d = Din;
          state_d = START;
        end
      end
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BCW'(BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: if (bit_tick) state_d = STOP;
`endif
      STOP: begin
        if (bit_tick) begin
          frame_done = rst;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so tx changes on the entering edge.
    unique case (state_d)
      START:   tx_d = LINE_START;
      DATA:    tx_d = shift_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      STOP:    tx_d = LINE_STOP;
      default: tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

`ifdef FIFO_SERIAL_TX_PARITY_EN
  always_comb parity_d = pop ? ^Din : parity_q;

  always_ff @(posedge clk) begin
    if (!rst) parity_q <= 1'b0;
    else      parity_q <= parity_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench for fifo_serial_tx with a queue-modelled FIFO upstream.
module tb_fifo_serial_tx;

  localparam int unsigned BITS = 8;
  localparam int unsigned C    = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int unsigned NB   = BITS + 3;
`else
  localparam int unsigned NB   = BITS + 2;
`endif
  localparam int unsigned FRAME = NB * C;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [BITS-1:0] din = '0;
  logic            pndng = 1'b0;
  logic            pop, tx, busy, frame_done;

  int n_vec = 0;
  int n_err = 0;

  logic [BITS-1:0] fifo_q[$];
  logic [BITS-1:0] exp_q[$];
  int              gaps[$];
  int              pop_cnt = 0;
  int              cyc = 0;
  int              last_pop = 0;
  bit              in_frame = 1'b0;

  fifo_serial_tx #(
    .BITS         (BITS),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Din        (din),
    .pndng      (pndng),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO model: pop removes the head on the same edge the DUT captures it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pop && rst) begin
      pop_cnt++;
      gaps.push_back(cyc - last_pop);
      last_pop = cyc;
      if (fifo_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL pop_on_empty: pop=1 with empty fifo at t=%0t", $time);
      end else begin
        void'(fifo_q.pop_front());
      end
      if (fifo_q.size() > 0) begin
        din   <= fifo_q[0];
        pndng <= 1'b1;
      end else begin
        pndng <= 1'b0;
      end
    end
  end

  task automatic push(input logic [BITS-1:0] w, input bit expect_it);
    fifo_q.push_back(w);
    if (expect_it) exp_q.push_back(w);
    din   = fifo_q[0];
    pndng = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (fifo_q.size() == 0 && !busy && !in_frame && !pop) done = 1'b1;
      else step();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: timeout after %0d cycles, busy=%0b", max_cyc, busy);
    end
  endtask

  // Monitor: decodes each frame from the line, sampling mid-bit after a pop.
  int              mon_cyc;
  logic [NB-1:0]   fb;
  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (pop) begin
        in_frame = 1'b1;
        mon_cyc  = 0;
        fb       = '0;
      end
    end else begin
      mon_cyc++;
      if ((mon_cyc - 1) % C == C / 2) fb[(mon_cyc - 1) / C] = tx;
      if (mon_cyc == 1) check("busy_first", {31'd0, busy}, 32'd1);
      if (mon_cyc == FRAME - 1) check("frame_done_early", {31'd0, frame_done}, 32'd0);
      if (mon_cyc == FRAME) begin
        in_frame = 1'b0;
        check("frame_done_last", {31'd0, frame_done}, 32'd1);
        check("busy_last", {31'd0, busy}, 32'd1);
        check("start_bit", {31'd0, fb[0]}, 32'd0);
        check("stop_bit", {31'd0, fb[NB-1]}, 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_frame: got 0x%0h expected none", fb[BITS:1]);
        end else begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
          check("parity_bit", {31'd0, fb[BITS+1]}, {31'd0, ^exp_q[0]});
`endif
          check("frame_word", {24'd0, fb[BITS:1]}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  localparam logic [BITS-1:0] BURST [16] = '{
    8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0,
    8'h12, 8'h34, 8'h9C, 8'hE7, 8'h3D, 8'h6B, 8'hC1, 8'h7E
  };

  initial begin
    int p0, bad;

    // Reset held with data pending: no pop, idle line.
    push(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pop", {31'd0, pop}, 32'd0);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check("pop_after_rst", {31'd0, pop}, 32'd1);
    wait_idle(200);

    // Full FIFO drained back-to-back.
    p0 = pop_cnt;
    gaps.delete();
    for (int i = 0; i < 16; i++) push(BURST[i], 1'b1);
    wait_idle(16 * (FRAME + 1) + 50);
    check("burst_pops", pop_cnt - p0, 32'd16);
    if (gaps.size() == 16)
      for (int i = 1; i < 16; i++) check("pop_spacing", gaps[i], FRAME + 1);
    check("burst_pndng", {31'd0, pndng}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin step(); if (tx !== 1'b1) bad++; end
    check("burst_tx_idle", bad, 32'd0);

    // Reset during data bit 3 of 0x3C; 0x5A queued behind it.
    push(8'h3C, 1'b0);
    push(8'h5A, 1'b1);
    for (int i = 0; i < 18; i++) step();
    rst = 1'b0;
    step();
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pop", {31'd0, pop}, 32'd0);
    rst = 1'b1;
    wait_idle(200);

    // Empty FIFO: no pops, idle line.
    p0  = pop_cnt;
    bad = 0;
    for (int i = 0; i < 200; i++) begin step(); if (tx !== 1'b1) bad++; end
    check("empty_pops", pop_cnt - p0, 32'd0);
    check("empty_tx", bad, 32'd0);

`ifdef FIFO_SERIAL_TX_PARITY_EN
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    wait_idle(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
